// File: rtl/data_memory.sv
`default_nettype none
// ============================================================================
// Module      : data_memory
// Description : Byte-addressable data memory and load/store unit for the
//               single-cycle RISC-V core. Little-endian B/H/W stores on the
//               rising edge; combinational sign/zero-extended loads;
//               misalignment and address/type fault detection with a sticky
//               error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [2:0]  Funct3,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Misaligned,
  output logic        AddrFault,
  output logic        ErrSticky
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] c_F3_B  = 3'b000;
  localparam logic [2:0] c_F3_H  = 3'b001;
  localparam logic [2:0] c_F3_W  = 3'b010;
  localparam logic [2:0] c_F3_BU = 3'b100;
  localparam logic [2:0] c_F3_HU = 3'b101;

  logic [31:0]   r_mem [DEPTH];
  logic          r_err_sticky;

  logic          w_access;
  logic          w_is_byte;
  logic          w_is_half;
  logic          w_is_word;
  logic          w_is_unsigned;
  logic          w_type_ok;
  logic          w_out_of_range;
  logic          w_fault;
  logic          w_we;
  logic [AW-1:0] w_idx;
  logic [1:0]    w_lane;
  logic [31:0]   w_word;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_load;
  logic [3:0]    w_wmask;
  logic [31:0]   w_wdata;

  // Access classification and fault detection
  assign w_access       = MemRead | MemWrite;
  assign w_is_byte      = (Funct3 == c_F3_B) | (Funct3 == c_F3_BU);
  assign w_is_half      = (Funct3 == c_F3_H) | (Funct3 == c_F3_HU);
  assign w_is_word      = (Funct3 == c_F3_W);
  assign w_is_unsigned  = (Funct3 == c_F3_BU) | (Funct3 == c_F3_HU);
  assign w_type_ok      = w_is_byte | w_is_half | w_is_word;
  // Any address bit above the word index means the byte address is past the array
  assign w_out_of_range = |(Addr >> (AW + 2));

  // Unsigned variants have no store meaning, so they fault when a store is requested
  assign AddrFault  = w_access & (w_out_of_range | ~w_type_ok | (MemWrite & w_is_unsigned));
  assign Misaligned = w_access & ((w_is_half & Addr[0]) | (w_is_word & (Addr[1:0] != 2'b00)));
  assign w_fault    = Misaligned | AddrFault;
  assign w_we       = MemWrite & ~w_fault;

  assign w_idx  = Addr[AW+1:2];
  assign w_lane = Addr[1:0];
  assign w_word = r_mem[w_idx];
  assign w_byte = w_word[{w_lane, 3'b000} +: 8];
  assign w_half = w_lane[1] ? w_word[31:16] : w_word[15:0];

  // Load extension by access type; faulted or disabled loads return zero
  always_comb begin
    w_load = 32'h0;
    case (Funct3)
      c_F3_B:  w_load = {{24{w_byte[7]}}, w_byte};
      c_F3_BU: w_load = {24'h0, w_byte};
      c_F3_H:  w_load = {{16{w_half[15]}}, w_half};
      c_F3_HU: w_load = {16'h0, w_half};
      c_F3_W:  w_load = w_word;
      default: w_load = 32'h0;
    endcase
    ReadData = (MemRead & ~w_fault) ? w_load : 32'h0;
  end

  // Store lane mask and lane-replicated store data
  always_comb begin
    w_wmask = 4'b0000;
    w_wdata = WriteData;
    if (w_is_byte) begin
      w_wmask = 4'b0001 << w_lane;
      w_wdata = {4{WriteData[7:0]}};
    end else if (w_is_half) begin
      w_wmask = w_lane[1] ? 4'b1100 : 4'b0011;
      w_wdata = {2{WriteData[15:0]}};
    end else if (w_is_word) begin
      w_wmask = 4'b1111;
      w_wdata = WriteData;
    end
  end

  // Memory array: asynchronous clear, per-lane write on the rising edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 32'h0;
      end
    end else if (w_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_wmask[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
        end
      end
    end
  end

  // Sticky error flag: latches any faulted access until reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_sticky <= 1'b0;
    end else if (w_fault) begin
      r_err_sticky <= 1'b1;
    end
  end

  assign ErrSticky = r_err_sticky;

endmodule
`default_nettype wire

// File: tb/tb_data_memory.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_memory
// Description : Self-checking bench for data_memory. A byte-array reference
//               model tracks the memory contents; a compare process checks
//               every DUT output on each falling edge, and directed
//               scenarios pin the model with literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory;

  localparam int DEPTH = 64;
  localparam int NBYTES = DEPTH * 4;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic        MemRead;
  logic [2:0]  Funct3;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Misaligned;
  logic        AddrFault;
  logic        ErrSticky;

  int total = 0;
  int bad   = 0;

  logic [7:0] m_mem [NBYTES];
  logic       m_sticky;

  data_memory #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .Funct3    (Funct3),
    .Addr      (Addr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Misaligned(Misaligned),
    .AddrFault (AddrFault),
    .ErrSticky (ErrSticky)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model (byte array, plain arithmetic) --------
  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic logic exp_misaligned();
    int n;
    n = size_of(Funct3);
    if (!(MemRead || MemWrite)) return 1'b0;
    if (n == 2 || n == 4) return (Addr % n) != 0;
    return 1'b0;
  endfunction

  function automatic logic exp_addrfault();
    if (!(MemRead || MemWrite)) return 1'b0;
    if (Addr >= 32'(NBYTES)) return 1'b1;
    if (size_of(Funct3) == 0) return 1'b1;
    if (MemWrite && (Funct3 == 3'b100 || Funct3 == 3'b101)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_readdata();
    int n;
    logic [31:0] v;
    n = size_of(Funct3);
    if (!MemRead || exp_misaligned() || exp_addrfault()) return 32'h0;
    v = 32'h0;
    for (int k = 0; k < n; k++) begin
      v = v | (32'(m_mem[int'(Addr) + k]) << (8 * k));
    end
    // Signed variants: replicate the top bit of the accessed item
    if ((Funct3 == 3'b000 || Funct3 == 3'b001) && v[8*n-1]) begin
      v = v | ~((32'h1 << (8 * n)) - 32'h1);
    end
    return v;
  endfunction

  // Model state update on the same edges as the design
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NBYTES; i++) m_mem[i] <= 8'h0;
      m_sticky <= 1'b0;
    end else begin
      if (exp_misaligned() || exp_addrfault()) begin
        m_sticky <= 1'b1;
      end else if (MemWrite) begin
        for (int k = 0; k < size_of(Funct3); k++) begin
          m_mem[int'(Addr) + k] <= WriteData[8*k +: 8];
        end
      end
    end
  end

  // Compare process: every output, every falling edge
  always @(negedge clk) begin
    logic [31:0] e_rd;
    logic        e_mis;
    logic        e_af;
    e_rd  = exp_readdata();
    e_mis = exp_misaligned();
    e_af  = exp_addrfault();
    total = total + 4;
    if (ReadData !== e_rd) begin
      bad = bad + 1;
      $display("FAIL cmp_ReadData t=%0t addr=%h f3=%b got=%h exp=%h", $time, Addr, Funct3, ReadData, e_rd);
    end
    if (Misaligned !== e_mis) begin
      bad = bad + 1;
      $display("FAIL cmp_Misaligned t=%0t addr=%h f3=%b got=%b exp=%b", $time, Addr, Funct3, Misaligned, e_mis);
    end
    if (AddrFault !== e_af) begin
      bad = bad + 1;
      $display("FAIL cmp_AddrFault t=%0t addr=%h f3=%b got=%b exp=%b", $time, Addr, Funct3, AddrFault, e_af);
    end
    if (ErrSticky !== m_sticky) begin
      bad = bad + 1;
      $display("FAIL cmp_ErrSticky t=%0t got=%b exp=%b", $time, ErrSticky, m_sticky);
    end
  end

  // ---------------- stimulus helpers --------------------------------------
  task automatic drive(input logic we, input logic re, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    @(posedge clk);
    #1;
    MemWrite  = we;
    MemRead   = re;
    Funct3    = f3;
    Addr      = a;
    WriteData = wd;
  endtask

  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic load_check(input string name, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] exp);
    drive(1'b0, 1'b1, f3, a, 32'h0);
    @(negedge clk);
    lit(name, ReadData, exp);
  endtask

  // ---------------- main sequence -----------------------------------------
  initial begin
    MemWrite  = 1'b0;
    MemRead   = 1'b0;
    Funct3    = 3'b010;
    Addr      = 32'h0;
    WriteData = 32'h0;
    reset     = 1'b0;
    #1 reset = 1'b1;
    @(negedge clk);
    lit("reset_sticky", {31'h0, ErrSticky}, 32'h0);
    lit("reset_readdata_idle", ReadData, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Mid-run reset clears a stored word
    drive(1'b1, 1'b0, 3'b010, 32'h10, 32'hDEADBEEF);
    load_check("pre_reset_lw", 3'b010, 32'h10, 32'hDEADBEEF);
    #2 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    load_check("post_reset_lw", 3'b010, 32'h10, 32'h0);
    lit("post_reset_sticky", {31'h0, ErrSticky}, 32'h0);

    // Word and byte loads with extension
    drive(1'b1, 1'b0, 3'b010, 32'h20, 32'h80817F01);
    load_check("lb_20",  3'b000, 32'h20, 32'h00000001);
    load_check("lb_23",  3'b000, 32'h23, 32'hFFFFFF80);
    load_check("lbu_23", 3'b100, 32'h23, 32'h00000080);
    load_check("lh_22",  3'b001, 32'h22, 32'hFFFF8081);
    load_check("lhu_22", 3'b101, 32'h22, 32'h00008081);
    load_check("lh_20",  3'b001, 32'h20, 32'h00007F01);

    // Lane merge over consecutive stores
    drive(1'b1, 1'b0, 3'b010, 32'h30, 32'h11223344);
    drive(1'b1, 1'b0, 3'b000, 32'h31, 32'h000000AA);
    drive(1'b1, 1'b0, 3'b001, 32'h32, 32'h0000BBCC);
    load_check("merge_lw_30", 3'b010, 32'h30, 32'hBBCCAA44);

    // Misaligned store is suppressed and sets the sticky flag
    drive(1'b1, 1'b0, 3'b010, 32'h41, 32'h12345678);
    @(negedge clk);
    lit("misaligned_flag", {31'h0, Misaligned}, 32'h1);
    load_check("misaligned_lw_40", 3'b010, 32'h40, 32'h0);
    lit("sticky_after_fault", {31'h0, ErrSticky}, 32'h1);
    drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    @(negedge clk);
    lit("sticky_held", {31'h0, ErrSticky}, 32'h1);

    // Out of range and invalid store type
    drive(1'b0, 1'b1, 3'b010, 32'h100, 32'h0);
    @(negedge clk);
    lit("oor_addrfault", {31'h0, AddrFault}, 32'h1);
    lit("oor_readdata", ReadData, 32'h0);
    drive(1'b1, 1'b0, 3'b011, 32'h0, 32'hFFFFFFFF);
    @(negedge clk);
    lit("inv_f3_addrfault", {31'h0, AddrFault}, 32'h1);
    load_check("inv_f3_lw_0", 3'b010, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 3'b100, 32'h4, 32'hFFFFFFFF);
    load_check("sbu_suppressed", 3'b010, 32'h4, 32'h0);

    // Read during write returns old data, then new
    drive(1'b1, 1'b0, 3'b010, 32'h8, 32'h5);
    drive(1'b1, 1'b1, 3'b010, 32'h8, 32'h9);
    @(negedge clk);
    lit("rdw_old", ReadData, 32'h5);
    load_check("rdw_new", 3'b010, 32'h8, 32'h9);

    // Reset clears sticky flag again
    #2 reset = 1'b1;
    @(negedge clk);
    lit("reset_clears_sticky", {31'h0, ErrSticky}, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Randomized traffic checked by the compare process
    for (int i = 0; i < 3000; i++) begin
      logic [2:0]  f3;
      logic [31:0] a;
      int          r;
      r = $urandom_range(0, 99);
      if (r < 30)      f3 = 3'b010;
      else if (r < 50) f3 = 3'b000;
      else if (r < 70) f3 = 3'b001;
      else if (r < 80) f3 = 3'b100;
      else if (r < 90) f3 = 3'b101;
      else             f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) a = $urandom();
      else                            a = 32'($urandom_range(0, NBYTES - 1));
      // Bias toward aligned addresses so stores mostly land
      if ($urandom_range(0, 3) != 0) begin
        if (f3 == 3'b010) a = a & ~32'h3;
        else if (f3 == 3'b001 || f3 == 3'b101) a = a & ~32'h1;
      end
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), f3, a, $urandom());
      if ($urandom_range(0, 299) == 0) begin
        #2 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
      end
    end

    drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the run always terminates
  initial begin
    #2000000;
    $display("FAIL timeout t=%0t got=running exp=finished", $time);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
